// File: rtl/pipe_hazard_arbiter_pkg.sv
// Shared constants for the pipeline hazard arbiter: stage indices and the
// per-hazard stall/flush masks used to assemble STALL_MASKS/FLUSH_MASKS.
package pipe_hazard_arbiter_pkg;

  localparam int STG_PC    = 0;
  localparam int STG_PREIF = 1;
  localparam int STG_IFID  = 2;
  localparam int STG_IDEX  = 3;
  localparam int STG_EXMEM = 4;
  localparam int STG_MEMWB = 5;

  typedef logic [5:0] stage_mask_t;

  // Stall freezes the listed registers; flush inserts a bubble into the listed registers.
  localparam stage_mask_t HZ_LOAD_USE_STALL = 6'b000111;
  localparam stage_mask_t HZ_LOAD_USE_FLUSH = 6'b001000;
  localparam stage_mask_t HZ_JUMP_STALL     = 6'b000000;
  localparam stage_mask_t HZ_JUMP_FLUSH     = 6'b000110;
  localparam stage_mask_t HZ_MULDIV_STALL   = 6'b001111;
  localparam stage_mask_t HZ_MULDIV_FLUSH   = 6'b010000;
  localparam stage_mask_t HZ_TRAP_STALL     = 6'b000000;
  localparam stage_mask_t HZ_TRAP_FLUSH     = 6'b011110;
  localparam stage_mask_t HZ_RAM_IF_STALL   = 6'b000011;
  localparam stage_mask_t HZ_RAM_IF_FLUSH   = 6'b000100;
  localparam stage_mask_t HZ_RAM_MEM_STALL  = 6'b011111;
  localparam stage_mask_t HZ_RAM_MEM_FLUSH  = 6'b100000;
  localparam stage_mask_t HZ_COMPRESS_STALL = 6'b000001;
  localparam stage_mask_t HZ_COMPRESS_FLUSH = 6'b000010;

endpackage

// File: rtl/pipe_hazard_arbiter_hazard_perf_cnt.sv
// Saturating stall-cycle counter with synchronous clear; one instance per
// hazard source.
module hazard_perf_cnt
  import pipe_hazard_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; the counter is an individual register, so it takes the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_arbiter.sv
// Pipeline stall/flush arbiter: priority or merge arbitration of hazard
// sources, pulse latching, stall watchdog and per-source stall counters.
module pipe_hazard_arbiter
  import pipe_hazard_arbiter_pkg::*;
#(
  parameter int                       NSTAGE      = 6,
  parameter int                       NREQ        = 8,
  parameter logic [NREQ*NSTAGE-1:0]   STALL_MASKS = '0,
  parameter logic [NREQ*NSTAGE-1:0]   FLUSH_MASKS = '0,
  parameter logic [NREQ-1:0]          PULSE_MASK  = '0,
  parameter int                       MERGE       = 0,
  parameter int                       WDOG_W      = 16,
  parameter int                       WDOG_LIMIT  = 1000,
  parameter int                       CNT_W       = 32,
  localparam int                      SEL_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   pend_o,
  output logic              wdog_o,
  input  logic              wdog_clr_i,
  input  logic [SEL_W-1:0]  perf_sel_i,
  input  logic              perf_clr_i,
  output logic [CNT_W-1:0]  perf_cnt_o
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT - 1);

  logic [NREQ-1:0]   r_pend;
  logic [NREQ-1:0]   w_eff;
  logic [NREQ-1:0]   w_grant;
  logic [NSTAGE-1:0] w_stall;
  logic [NSTAGE-1:0] w_flush;
  logic              w_found;
  logic [WDOG_W-1:0] r_wcnt;
  logic              r_wdog;
  logic [CNT_W-1:0]  w_cnt [NREQ];
  logic [CNT_W-1:0]  w_perf_sel;
  logic [CNT_W-1:0]  r_perf;

  assign w_eff = req_i | r_pend;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_stall = '0;
    w_flush = '0;
    w_grant = '0;
    w_found = 1'b0;
    if (MERGE != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_eff[i]) w_stall |= STALL_MASKS[i*NSTAGE +: NSTAGE];
      end
      // A source whose flush would hit a stalled stage is held off this cycle.
      for (int i = 0; i < NREQ; i++) begin
        if (w_eff[i] && ((FLUSH_MASKS[i*NSTAGE +: NSTAGE] & w_stall) == '0)) begin
          w_grant[i] = 1'b1;
          w_flush   |= FLUSH_MASKS[i*NSTAGE +: NSTAGE];
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_eff[i] && !w_found) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_stall    = STALL_MASKS[i*NSTAGE +: NSTAGE];
          w_flush    = FLUSH_MASKS[i*NSTAGE +: NSTAGE];
        end
      end
    end
  end

  assign stall_o    = rst ? '0 : w_stall;
  assign flush_o    = rst ? '1 : w_flush;
  assign grant_o    = rst ? '0 : w_grant;
  assign pend_o     = r_pend;
  assign wdog_o     = r_wdog;
  assign perf_cnt_o = r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_eff & ~w_grant & PULSE_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
      r_wdog <= 1'b0;
    end else if (wdog_clr_i) begin
      r_wcnt <= '0;
      r_wdog <= 1'b0;
    end else if (w_stall[STG_PC]) begin
      if (r_wcnt == WDOG_MAX) r_wdog <= 1'b1;
      else                    r_wcnt <= r_wcnt + WDOG_W'(1);
    end else begin
      r_wcnt <= '0;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    hazard_perf_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (perf_clr_i),
      .inc_i (w_grant[g] && (STALL_MASKS[g*NSTAGE +: NSTAGE] != '0)),
      .cnt_o (w_cnt[g])
    );
  end

  always_comb begin
    w_perf_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (perf_sel_i == SEL_W'(i)) w_perf_sel = w_cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_perf <= '0;
    else     r_perf <= w_perf_sel;
  end

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// Self-checking bench: a priority-mode and a merge-mode arbiter share stimulus
// and are compared each cycle against a behavioural model.
module tb_pipe_hazard_arbiter;

  localparam int          NS    = 6;
  localparam int          NR    = 3;
  localparam int          CW    = 4;
  localparam int          WL    = 4;
  localparam int          CMAX  = 15;
  localparam logic [17:0] SMASK = {6'b000111, 6'b000010, 6'b011111};
  localparam logic [17:0] FMASK = {6'b001000, 6'b001110, 6'b100000};
  localparam logic [2:0]  PMASK = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic          wdog_clr;
  logic          perf_clr;
  logic [1:0]    perf_sel;

  logic [NS-1:0] dut_stall [2];
  logic [NS-1:0] dut_flush [2];
  logic [NR-1:0] dut_grant [2];
  logic [NR-1:0] dut_pend  [2];
  logic          dut_wdog  [2];
  logic [CW-1:0] dut_perf  [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] mdl_pend [2];
  int         mdl_run  [2];
  bit         mdl_wdog [2];
  int         mdl_cnt  [2][3];
  int         mdl_perf [2];

  initial forever #5 clk = ~clk;

  pipe_hazard_arbiter #(
    .NSTAGE(NS), .NREQ(NR), .STALL_MASKS(SMASK), .FLUSH_MASKS(FMASK),
    .PULSE_MASK(PMASK), .MERGE(0), .WDOG_W(8), .WDOG_LIMIT(WL), .CNT_W(CW)
  ) u_dut_pri (
    .clk(clk), .rst(rst), .req_i(req), .stall_o(dut_stall[0]), .flush_o(dut_flush[0]),
    .grant_o(dut_grant[0]), .pend_o(dut_pend[0]), .wdog_o(dut_wdog[0]),
    .wdog_clr_i(wdog_clr), .perf_sel_i(perf_sel), .perf_clr_i(perf_clr),
    .perf_cnt_o(dut_perf[0])
  );

  pipe_hazard_arbiter #(
    .NSTAGE(NS), .NREQ(NR), .STALL_MASKS(SMASK), .FLUSH_MASKS(FMASK),
    .PULSE_MASK(PMASK), .MERGE(1), .WDOG_W(8), .WDOG_LIMIT(WL), .CNT_W(CW)
  ) u_dut_mrg (
    .clk(clk), .rst(rst), .req_i(req), .stall_o(dut_stall[1]), .flush_o(dut_flush[1]),
    .grant_o(dut_grant[1]), .pend_o(dut_pend[1]), .wdog_o(dut_wdog[1]),
    .wdog_clr_i(wdog_clr), .perf_sel_i(perf_sel), .perf_clr_i(perf_clr),
    .perf_cnt_o(dut_perf[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Arbitration rules over the mask table: mode 0 = lowest index wins,
  // mode 1 = union of stalls, grant only sources whose flush avoids the stall.
  function automatic void arb(input int mode, input logic [2:0] eff,
                              output logic [5:0] st, output logic [5:0] fl,
                              output logic [2:0] gr);
    st = '0; fl = '0; gr = '0;
    if (mode == 0) begin
      for (int i = 0; i < NR; i++) begin
        if (eff[i]) begin
          st = SMASK[i*NS +: NS]; fl = FMASK[i*NS +: NS]; gr[i] = 1'b1;
          break;
        end
      end
    end else begin
      for (int i = 0; i < NR; i++) if (eff[i]) st |= SMASK[i*NS +: NS];
      for (int i = 0; i < NR; i++) begin
        if (eff[i] && ((FMASK[i*NS +: NS] & st) == 6'd0)) begin
          gr[i] = 1'b1; fl |= FMASK[i*NS +: NS];
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mdl_pend[m] = '0; mdl_run[m] = 0; mdl_wdog[m] = 1'b0; mdl_perf[m] = 0;
      for (int i = 0; i < NR; i++) mdl_cnt[m][i] = 0;
    end
  endtask

  task automatic model_clock();
    logic [2:0] eff, gr;
    logic [5:0] st, fl;
    for (int m = 0; m < 2; m++) begin
      eff = req | mdl_pend[m];
      arb(m, eff, st, fl, gr);
      mdl_perf[m] = (int'(perf_sel) < NR) ? mdl_cnt[m][int'(perf_sel)] : 0;
      for (int i = 0; i < NR; i++) begin
        if (perf_clr) mdl_cnt[m][i] = 0;
        else if (gr[i] && (SMASK[i*NS +: NS] != 6'd0))
          mdl_cnt[m][i] = (mdl_cnt[m][i] + 1 > CMAX) ? CMAX : mdl_cnt[m][i] + 1;
      end
      if (wdog_clr) begin
        mdl_run[m] = 0; mdl_wdog[m] = 1'b0;
      end else if (st[0]) begin
        mdl_run[m]++;
        if (mdl_run[m] >= WL) mdl_wdog[m] = 1'b1;
      end else begin
        mdl_run[m] = 0;
      end
      mdl_pend[m] = eff & ~gr & PMASK;
    end
  endtask

  task automatic compare_outputs();
    logic [2:0] gr;
    logic [5:0] st, fl;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        st = 6'd0; fl = 6'h3f; gr = 3'd0;
      end else begin
        arb(m, req | mdl_pend[m], st, fl, gr);
      end
      check($sformatf("m%0d stall", m), 32'(dut_stall[m]), 32'(st));
      check($sformatf("m%0d flush", m), 32'(dut_flush[m]), 32'(fl));
      check($sformatf("m%0d grant", m), 32'(dut_grant[m]), 32'(gr));
      check($sformatf("m%0d pend",  m), 32'(dut_pend[m]),  32'(mdl_pend[m]));
      check($sformatf("m%0d wdog",  m), 32'(dut_wdog[m]),  32'(mdl_wdog[m]));
      check($sformatf("m%0d perf",  m), 32'(dut_perf[m]),  32'(mdl_perf[m]));
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic to_pos();
    @(posedge clk);
    if (!rst) model_clock();
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; wdog_clr = 1'b0; perf_clr = 1'b0; perf_sel = '0;
    model_reset();
    to_neg();
    check("rst flush", 32'(dut_flush[0]), 32'h3f);
    check("rst stall", 32'(dut_stall[0]), 32'h00);
    to_pos();
    to_neg(); to_pos();
    rst = 1'b0;

    // Priority arbitration between sources 1 and 2, then source 2 alone
    req = 3'b110; to_neg();
    check("pri110 stall", 32'(dut_stall[0]), 32'b000010);
    check("pri110 flush", 32'(dut_flush[0]), 32'b001110);
    check("pri110 grant", 32'(dut_grant[0]), 32'b010);
    to_pos();
    req = 3'b100; to_neg();
    check("pri100 stall", 32'(dut_stall[0]), 32'b000111);
    check("pri100 flush", 32'(dut_flush[0]), 32'b001000);
    to_pos();

    // Losing pulse on source 1 is latched and served exactly once
    req = 3'b000; to_neg(); to_pos();
    req = 3'b011; to_neg();
    check("pulse grant", 32'(dut_grant[0]), 32'b001);
    to_pos();
    req = 3'b000; to_neg();
    check("pulse pend",  32'(dut_pend[0]),  32'b010);
    check("pulse stall", 32'(dut_stall[0]), 32'b000010);
    check("pulse flush", 32'(dut_flush[0]), 32'b001110);
    to_pos();
    to_neg();
    check("pulse pend clr",  32'(dut_pend[0]),  32'b000);
    check("pulse stall clr", 32'(dut_stall[0]), 32'b000000);
    to_pos();

    // Merge mode: source 2 flush collides with the union stall
    req = 3'b101; to_neg();
    check("mrg stall", 32'(dut_stall[1]), 32'b011111);
    check("mrg grant", 32'(dut_grant[1]), 32'b001);
    check("mrg flush", 32'(dut_flush[1]), 32'b100000);
    to_pos();

    // Watchdog trips after WL consecutive PC stalls, sticky until cleared
    req = 3'b000; to_neg(); to_pos();
    req = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      to_neg();
      if (k == 4) check("wdog before", 32'(dut_wdog[0]), 32'd0);
      if (k == 5) check("wdog trip",   32'(dut_wdog[0]), 32'd1);
      to_pos();
    end
    req = 3'b000; to_neg();
    check("wdog sticky", 32'(dut_wdog[0]), 32'd1);
    to_pos();
    wdog_clr = 1'b1; to_neg(); to_pos();
    wdog_clr = 1'b0; to_neg();
    check("wdog clr", 32'(dut_wdog[0]), 32'd0);
    to_pos();

    // Counter saturation, then clear racing an increment
    perf_sel = 2'd0; req = 3'b001;
    repeat (20) begin to_neg(); to_pos(); end
    perf_clr = 1'b1; to_neg();
    check("perf sat", 32'(dut_perf[0]), 32'd15);
    to_pos();
    perf_clr = 1'b0; req = 3'b000; to_neg(); to_pos();
    to_neg();
    check("perf clr", 32'(dut_perf[0]), 32'd0);
    to_pos();

    // Asynchronous reset while stalled with a pending pulse
    req = 3'b011; to_neg(); to_pos();
    req = 3'b001; to_neg();
    check("pre-rst pend", 32'(dut_pend[0]), 32'b010);
    #2 rst = 1'b1;
    #1;
    check("arst stall", 32'(dut_stall[0]), 32'h00);
    check("arst flush", 32'(dut_flush[0]), 32'h3f);
    check("arst pend",  32'(dut_pend[0]),  32'h0);
    check("arst wdog",  32'(dut_wdog[0]),  32'h0);
    model_reset();
    to_pos();
    to_neg(); to_pos();
    rst = 1'b0;

    // Randomised traffic with occasional clears, out-of-range selects and resets
    for (int k = 0; k < 400; k++) begin
      req      = 3'($urandom_range(0, 7));
      wdog_clr = ($urandom_range(0, 15) == 0);
      perf_clr = ($urandom_range(0, 31) == 0);
      perf_sel = 2'($urandom_range(0, 3));
      to_neg();
      if ((k % 128) == 100) begin
        #2 rst = 1'b1;
        #1 model_reset();
        compare_outputs();
      end
      to_pos();
      if (rst) rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
